// File: rtl/onchip_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onchip_arb_pkg
// Description : Shared types and default widths for the two-requester
//               on-chip memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package onchip_arb_pkg;

  localparam int c_ADDR_W_DEF   = 13;
  localparam int c_DATA_W_DEF   = 64;
  localparam int c_LOCK_MAX_DEF = 16;

  // Index of one of the two requesters
  typedef logic [0:0] req_idx_t;

  // Arbitration state: open round-robin or held by a locked owner
  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // The requester that is not idx
  function automatic req_idx_t other_req(input req_idx_t idx);
    return ~idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way combinational grant select with a round-robin
//               priority pointer. A forced owner (lock) overrides the
//               pointer on contention.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_force_en,
  input  req_idx_t   i_force_idx,
  output logic       o_grant_valid,
  output req_idx_t   o_grant_idx
);

  req_idx_t r_prio;
  req_idx_t w_prio;

  // Pick the winner: a sole requester wins outright, contention goes to w_prio
  always_comb begin
    w_prio        = i_force_en ? i_force_idx : r_prio;
    o_grant_valid = |i_req;
    if (&i_req) begin
      o_grant_idx = w_prio;
    end else if (i_req[1]) begin
      o_grant_idx = 1'b1;
    end else begin
      o_grant_idx = 1'b0;
    end
  end

  // After every grant the other requester becomes the preferred one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= '0;
    end else if (o_grant_valid) begin
      r_prio <= other_req(o_grant_idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/onchip_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onchip_memory_arbiter
// Description : Arbitrates two requesters onto one single-cycle-latency
//               on-chip memory port. Round-robin grant, one access per
//               cycle, read data strobed one cycle after acceptance.
//               Define ONCHIP_ARB_LOCK_EN to build in bus locking
//               (owner keeps the port for up to LOCK_MAX grants).
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_memory_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int  ADDR_W   = c_ADDR_W_DEF,
  parameter int  DATA_W   = c_DATA_W_DEF,
  parameter int  LOCK_MAX = c_LOCK_MAX_DEF,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // requester 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // memory side
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0]        w_req;
  logic              w_grant_valid;
  req_idx_t          w_grant_idx;
  logic              w_force_en;
  req_idx_t          w_force_idx;

  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_read;
  logic              w_sel_write;
  logic              w_sel_lock;

  logic [ADDR_W-1:0] r_hold_addr;
  logic [BE_W-1:0]   r_hold_be;
  logic [DATA_W-1:0] r_hold_wdata;
  logic [1:0]        r_rdv;

  // Requests are masked during reset so nothing is granted and waitrequest stays high
  assign w_req[0] = reset_n & (m0_read | m0_write);
  assign w_req[1] = reset_n & (m1_read | m1_write);

  rr_arbiter2 u_rr_arbiter2 (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_req         (w_req),
    .i_force_en    (w_force_en),
    .i_force_idx   (w_force_idx),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Steer the granted requester's command fields
  always_comb begin
    if (w_grant_idx == 1'b1) begin
      w_sel_addr  = m1_address;
      w_sel_be    = m1_byteenable;
      w_sel_wdata = m1_writedata;
      w_sel_read  = m1_read;
      w_sel_write = m1_write;
      w_sel_lock  = m1_lock;
    end else begin
      w_sel_addr  = m0_address;
      w_sel_be    = m0_byteenable;
      w_sel_wdata = m0_writedata;
      w_sel_read  = m0_read;
      w_sel_write = m0_write;
      w_sel_lock  = m0_lock;
    end
  end

`ifdef ONCHIP_ARB_LOCK_EN
  localparam int c_CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t         r_state;
  req_idx_t           r_owner;
  logic [c_CNT_W-1:0] r_lock_cnt;

  assign w_force_en  = (r_state == ST_LOCKED);
  assign w_force_idx = r_owner;

  // Lock FSM: the first locked grant counts as one; release on unlock, owner idle or limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_ARB;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_grant_valid && w_sel_lock && (LOCK_MAX > 1)) begin
            r_state    <= ST_LOCKED;
            r_owner    <= w_grant_idx;
            r_lock_cnt <= c_CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!w_req[r_owner] || !w_sel_lock ||
              (r_lock_cnt >= c_CNT_W'(LOCK_MAX - 1))) begin
            r_state    <= ST_ARB;
            r_lock_cnt <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_ARB;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end
`else
  localparam int c_unused_lock_max = LOCK_MAX;
  logic w_unused_lock;

  assign w_unused_lock = w_sel_lock;
  assign w_force_en    = 1'b0;
  assign w_force_idx   = '0;
`endif

  // Remember the last issued command so the memory bus is stable while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_addr  <= '0;
      r_hold_be    <= '0;
      r_hold_wdata <= '0;
    end else if (w_grant_valid) begin
      r_hold_addr  <= w_sel_addr;
      r_hold_be    <= w_sel_be;
      r_hold_wdata <= w_sel_wdata;
    end
  end

  // Flag an accepted read (write wins when both are set) for next-cycle data return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdv <= '0;
    end else begin
      r_rdv[0] <= w_grant_valid && (w_grant_idx == 1'b0) && w_sel_read && !w_sel_write;
      r_rdv[1] <= w_grant_valid && (w_grant_idx == 1'b1) && w_sel_read && !w_sel_write;
    end
  end

  assign mem_address    = w_grant_valid ? w_sel_addr  : r_hold_addr;
  assign mem_byteenable = w_grant_valid ? w_sel_be    : r_hold_be;
  assign mem_writedata  = w_grant_valid ? w_sel_wdata : r_hold_wdata;
  assign mem_chipselect = w_grant_valid;
  assign mem_write      = w_grant_valid & w_sel_write;

  assign m0_waitrequest = !(w_grant_valid && (w_grant_idx == 1'b0));
  assign m1_waitrequest = !(w_grant_valid && (w_grant_idx == 1'b1));

  assign m0_readdatavalid = r_rdv[0];
  assign m1_readdatavalid = r_rdv[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
`default_nettype wire
